// File: rtl/warmboot_sequencer_if.sv
// Signal bundle between the bootloader side of the board top and warmboot_sequencer.
// boot_req is a level whose rising edge requests a boot; there is no ready, and edges seen while busy are dropped.
interface warmboot_sequencer_if;
   logic       boot_req;
   logic [1:0] image_sel;
   logic       spi_cs;
   logic       usb_pu;
   logic       wb_s1;
   logic       wb_s0;
   logic       wb_boot;
   logic       busy;
   logic [2:0] dbg_state;

   modport master (
      output boot_req, image_sel, spi_cs,
      input  usb_pu, wb_s1, wb_s0, wb_boot, busy, dbg_state
   );

   modport slave (
      input  boot_req, image_sel, spi_cs,
      output usb_pu, wb_s1, wb_s0, wb_boot, busy, dbg_state
   );
endinterface

// File: rtl/warmboot_sequencer.sv
// Orderly hand-off from the bootloader to the user image: wait for flash idle,
// drop the USB pull-up for a host-visible disconnect, then pulse SB_WARMBOOT.
module warmboot_sequencer #(
   parameter int unsigned SETTLE_CYCLES    = 64,
   parameter int unsigned DETACH_CYCLES    = 480000,
   parameter int unsigned BOOT_HOLD_CYCLES = 16
) (
   input  logic                 clk_48mhz,
   input  logic                 reset,
   warmboot_sequencer_if.slave  bus
);

   localparam int unsigned MAX_A = (SETTLE_CYCLES > DETACH_CYCLES) ? SETTLE_CYCLES : DETACH_CYCLES;
   localparam int unsigned MAX_C = (MAX_A > BOOT_HOLD_CYCLES) ? MAX_A : BOOT_HOLD_CYCLES;
   localparam int unsigned CW    = $clog2(MAX_C + 1);

   localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
   localparam logic [CW-1:0] DETACH_LAST = CW'(DETACH_CYCLES - 1);
   localparam logic [CW-1:0] BOOT_LAST   = CW'(BOOT_HOLD_CYCLES - 1);
   localparam logic [CW-1:0] CNT_ONE     = CW'(1);

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      WAIT_SPI = 3'd1,
      DETACH   = 3'd2,
      ARM      = 3'd3,
      FIRE     = 3'd4,
      HALT     = 3'd5
   } state_e;

   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      sel_q, sel_d;
   logic            boot_req_q;
   logic            req_edge;

   assign req_edge = bus.boot_req & ~boot_req_q;

   // boot_req_q resets high so a request held through reset is not taken as an edge.
   always_ff @(posedge clk_48mhz) begin
      if (reset) begin
         state_q    <= IDLE;
         cnt_q      <= '0;
         sel_q      <= 2'b00;
         boot_req_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sel_q      <= sel_d;
         boot_req_q <= bus.boot_req;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      sel_d   = sel_q;
      unique case (state_q)
         IDLE: begin
            if (req_edge) begin
               sel_d   = bus.image_sel;
               state_d = WAIT_SPI;
               cnt_d   = '0;
            end
         end
         WAIT_SPI: begin
            // Any low sample restarts the settle window.
            if (!bus.spi_cs) begin
               cnt_d = '0;
            end else if (cnt_q == SETTLE_LAST) begin
               state_d = DETACH;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         DETACH: begin
            if (cnt_q == DETACH_LAST) begin
               state_d = ARM;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         ARM: begin
            state_d = FIRE;
            cnt_d   = '0;
         end
         FIRE: begin
            if (cnt_q == BOOT_LAST) begin
               state_d = HALT;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         HALT: begin
            state_d = HALT;
         end
         default: begin
            state_d = IDLE;
            cnt_d   = '0;
         end
      endcase
   end

   // Outputs decode registered state only, so they move on the same edge as the state.
   always_comb begin
      bus.usb_pu    = (state_q == IDLE) || (state_q == WAIT_SPI);
      bus.wb_boot   = (state_q == FIRE);
      bus.busy      = (state_q != IDLE);
      bus.wb_s1     = 1'b0;
      bus.wb_s0     = 1'b0;
      bus.dbg_state = state_q;
      if ((state_q == ARM) || (state_q == FIRE) || (state_q == HALT)) begin
         bus.wb_s1 = sel_q[1];
         bus.wb_s0 = sel_q[0];
      end
   end

endmodule

// File: tb/tb_warmboot_sequencer.sv
// Self-checking bench for warmboot_sequencer with a phase-timeline reference model.
module tb_warmboot_sequencer;

   localparam int SETTLE    = 4;
   localparam int DETACH    = 100;
   localparam int BOOT_HOLD = 3;

   logic clk;
   logic rst;
   int   errors;
   int   checks;

   warmboot_sequencer_if bus();

   warmboot_sequencer #(
      .SETTLE_CYCLES    (SETTLE),
      .DETACH_CYCLES    (DETACH),
      .BOOT_HOLD_CYCLES (BOOT_HOLD)
   ) dut (
      .clk_48mhz (clk),
      .reset     (rst),
      .bus       (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog time limit reached");
      errors = errors + 1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $fatal(1, "watchdog");
   end

   task automatic apply_reset(input string name);
      @(negedge clk);
      rst          = 1'b1;
      bus.boot_req = 1'b0;
      bus.spi_cs   = 1'b1;
      @(negedge clk);
      checks = checks + 4;
      if (bus.usb_pu !== 1'b1) begin errors++; $display("FAIL %s usb_pu got=%b exp=1", name, bus.usb_pu); end
      if (bus.wb_boot !== 1'b0) begin errors++; $display("FAIL %s wb_boot got=%b exp=0", name, bus.wb_boot); end
      if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s busy got=%b exp=0", name, bus.busy); end
      if ({bus.wb_s1, bus.wb_s0} !== 2'b00) begin
         errors++; $display("FAIL %s wb_s got=%b%b exp=00", name, bus.wb_s1, bus.wb_s0);
      end
      rst = 1'b0;
   endtask

   // Reference model: the request edge lands at edge T. Phase boundaries are derived
   // from the spi_cs sample sequence: DETACH starts after edge T+d, where d is the first
   // edge ending a run of SETTLE consecutive high samples; the rest is fixed durations.
   // pat[k-1] is the spi_cs value sampled at edge T+k (k beyond n_pat samples 1).
   task automatic run_seq(input string name, input logic [1:0] sel, input int n_pat,
                          input logic [31:0] pat, input bit perturb, input int abort_rel);
      int   d;
      int   run;
      int   last;
      int   k;
      logic s;
      logic exp_pu, exp_boot;
      logic [1:0] exp_s;
      d   = 0;
      run = 0;
      for (int i = 1; d == 0 && i < 200; i++) begin
         s   = (i <= n_pat) ? pat[i-1] : 1'b1;
         run = s ? run + 1 : 0;
         if (run == SETTLE) d = i;
      end
      @(negedge clk);
      bus.boot_req = 1'b0;
      bus.spi_cs   = 1'b1;
      @(negedge clk);
      bus.boot_req  = 1'b1;
      bus.image_sel = sel;
      last = d + DETACH + BOOT_HOLD + 4;
      for (int j = 0; j <= last; j++) begin
         @(negedge clk);
         exp_pu   = (j < d);
         exp_s    = (j >= d + DETACH) ? sel : 2'b00;
         exp_boot = (j >= d + DETACH + 1) && (j <= d + DETACH + BOOT_HOLD);
         checks = checks + 4;
         if (bus.busy !== 1'b1) begin
            errors++; $display("FAIL %s busy j=%0d got=%b exp=1", name, j, bus.busy);
         end
         if (bus.usb_pu !== exp_pu) begin
            errors++; $display("FAIL %s usb_pu j=%0d got=%b exp=%b", name, j, bus.usb_pu, exp_pu);
         end
         if ({bus.wb_s1, bus.wb_s0} !== exp_s) begin
            errors++; $display("FAIL %s wb_s j=%0d got=%b%b exp=%b", name, j, bus.wb_s1, bus.wb_s0, exp_s);
         end
         if (bus.wb_boot !== exp_boot) begin
            errors++; $display("FAIL %s wb_boot j=%0d got=%b exp=%b", name, j, bus.wb_boot, exp_boot);
         end
         if (abort_rel >= 0 && j == d + abort_rel) begin
            rst = 1'b1;
            @(negedge clk);
            checks = checks + 4;
            if (bus.usb_pu !== 1'b1) begin errors++; $display("FAIL %s abort usb_pu got=%b exp=1", name, bus.usb_pu); end
            if (bus.wb_boot !== 1'b0) begin errors++; $display("FAIL %s abort wb_boot got=%b exp=0", name, bus.wb_boot); end
            if (bus.busy !== 1'b0) begin errors++; $display("FAIL %s abort busy got=%b exp=0", name, bus.busy); end
            if ({bus.wb_s1, bus.wb_s0} !== 2'b00) begin
               errors++; $display("FAIL %s abort wb_s got=%b%b exp=00", name, bus.wb_s1, bus.wb_s0);
            end
            rst          = 1'b0;
            bus.boot_req = 1'b0;
            return;
         end
         k = j + 1;
         bus.spi_cs = (k <= n_pat) ? pat[k-1] : 1'b1;
         if (perturb) begin
            bus.image_sel = (j == 0) ? ~sel : 2'($urandom_range(0, 3));
            if (j == d + 5)      bus.boot_req = 1'b0;
            else if (j == d + 6) bus.boot_req = 1'b1;
            else                 bus.boot_req = 1'($urandom_range(0, 1));
         end
      end
      bus.boot_req = 1'b0;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      @(negedge clk);
      rst           = 1'b1;
      bus.boot_req  = 1'b1;
      bus.image_sel = 2'b11;
      bus.spi_cs    = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         checks = checks + 4;
         if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_hold busy i=%0d got=%b exp=0", i, bus.busy); end
         if (bus.usb_pu !== 1'b1) begin errors++; $display("FAIL reset_hold usb_pu i=%0d got=%b exp=1", i, bus.usb_pu); end
         if (bus.wb_boot !== 1'b0) begin errors++; $display("FAIL reset_hold wb_boot i=%0d got=%b exp=0", i, bus.wb_boot); end
         if ({bus.wb_s1, bus.wb_s0} !== 2'b00) begin
            errors++; $display("FAIL reset_hold wb_s i=%0d got=%b%b exp=00", i, bus.wb_s1, bus.wb_s0);
         end
      end
      bus.boot_req = 1'b0;
      @(negedge clk);
      bus.boot_req = 1'b1;
      @(negedge clk);
      checks = checks + 1;
      if (bus.busy !== 1'b1) begin errors++; $display("FAIL reset_reedge busy got=%b exp=1", bus.busy); end
      apply_reset("reset_clear");
   endtask

   task automatic test_nominal();
      run_seq("nominal", 2'b01, 0, 32'h0, 1'b0, -1);
      apply_reset("nominal_rst");
   endtask

   task automatic test_spi_glitch();
      run_seq("spi_glitch", 2'b11, 4, 32'b0111, 1'b0, -1);
      apply_reset("spi_glitch_rst");
      run_seq("spi_busy_long", 2'b01, 20, 32'h000F_0000, 1'b0, -1);
      apply_reset("spi_busy_long_rst");
   endtask

   task automatic test_sel_change();
      run_seq("sel_change", 2'b10, 0, 32'h0, 1'b1, -1);
      apply_reset("sel_change_rst");
   endtask

   task automatic test_req_during_detach();
      run_seq("req_in_detach", 2'b01, 2, 32'b10, 1'b1, -1);
      apply_reset("req_in_detach_rst");
   endtask

   task automatic test_reset_in_fire();
      run_seq("fire_abort", 2'b01, 0, 32'h0, 1'b0, DETACH + 2);
      run_seq("fire_replay", 2'b01, 0, 32'h0, 1'b0, -1);
      apply_reset("fire_replay_rst");
   endtask

   task automatic test_random();
      logic [1:0]  sel;
      int          n;
      logic [31:0] pat;
      bit          pert;
      for (int r = 0; r < 6; r++) begin
         sel  = 2'($urandom_range(0, 3));
         n    = $urandom_range(0, 12);
         pat  = $urandom;
         pert = 1'($urandom_range(0, 1));
         run_seq($sformatf("random%0d", r), sel, n, pat, pert, -1);
         apply_reset("random_rst");
      end
   endtask

   initial begin
      errors        = 0;
      checks        = 0;
      rst           = 1'b1;
      bus.boot_req  = 1'b0;
      bus.image_sel = 2'b00;
      bus.spi_cs    = 1'b1;
      test_reset();
      test_nominal();
      test_spi_glitch();
      test_sel_change();
      test_req_during_detach();
      test_reset_in_fire();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/warmboot_sequencer.md
Name: warmboot_sequencer

Overview:
Sits directly downstream of tinyfpga_bootloader on the board top. It consumes the bootloader's boot request and performs an orderly hand-off to the user image:
- waits for the SPI flash to go idle;
- detaches from USB by dropping the D+ pull-up long enough for the host to see a disconnect;
- drives the iCE40 SB_WARMBOOT S1/S0/BOOT inputs.

It replaces the constant pull-up tie and the disabled warmboot instance in the board top.

Parameters:
SETTLE_CYCLES, 64, consecutive cycles spi_cs must read high (flash deselected) before detach begins; >=1
DETACH_CYCLES, 480000, cycles usb_pu is held low before warmboot (10 ms at 48 MHz); >=1
BOOT_HOLD_CYCLES, 16, cycles wb_boot is held high; >=1

Ports:
clk_48mhz  input  1  system clock, 48 MHz from USB PLL
reset  input  1  synchronous, active-high reset
boot_req  input  1  boot request from tinyfpga_bootloader; rising edge starts sequence
image_sel  input  2  warmboot image index; sampled on accepted request edge
spi_cs  input  1  observed flash chip select (active low; 1 = idle)
usb_pu  output  1  USB D+ pull-up enable to pin_pu; 1 = attached
wb_s1  output  1  SB_WARMBOOT S1
wb_s0  output  1  SB_WARMBOOT S0
wb_boot  output  1  SB_WARMBOOT BOOT
busy  output  1  1 whenever state != IDLE

Behaviour:
- Clocking and outputs:
  - Single clock domain, clk_48mhz; reset is synchronous and active-high.
  - Moore machine: all outputs decode registered state and registers only; no input-to-output combinational path.
  - Outputs change on the same edge as the state change.
- Reset values: state=IDLE, usb_pu=1, wb_boot=0, {wb_s1,wb_s0}=2'b00, busy=0, counter=0, sel_q=2'b00, boot_req_q=1.
  - Because boot_req_q resets to 1, a boot_req held high through reset release is not an edge. It must fall and rise again to start a sequence.
- Edge detect: req_edge = boot_req & ~boot_req_q. boot_req_q <= boot_req every cycle.
- Counter width: $clog2(max(SETTLE_CYCLES, DETACH_CYCLES, BOOT_HOLD_CYCLES)+1). The counter clears on every state transition.
- State transitions:
  - IDLE: if req_edge, latch sel_q<=image_sel, go to WAIT_SPI. Otherwise hold.
  - WAIT_SPI: if spi_cs==0, counter<=0. Otherwise counter++. When spi_cs==1 and counter==SETTLE_CYCLES-1, go to DETACH. That is, exactly SETTLE_CYCLES consecutive high samples are required.
  - DETACH: counter++. At counter==DETACH_CYCLES-1, go to ARM.
  - ARM: one cycle only, setting up S1/S0 before BOOT. Go to FIRE.
  - FIRE: counter++. At counter==BOOT_HOLD_CYCLES-1, go to HALT.
  - HALT: terminal. In silicon the FPGA reconfigures; in simulation the block stays here until reset.
- Output decode by state:
  - usb_pu = 1 in IDLE and WAIT_SPI; 0 in DETACH, ARM, FIRE and HALT. The device never re-attaches before warmboot.
  - {wb_s1,wb_s0} = 2'b00 in IDLE, WAIT_SPI and DETACH; = sel_q in ARM, FIRE and HALT.
  - wb_boot = 1 only in FIRE.
- Boundary conditions:
  - req_edge in any state other than IDLE is ignored. sel_q is not updated.
  - image_sel changes after the accepted edge have no effect.
  - spi_cs never going high leaves the block in WAIT_SPI indefinitely with usb_pu=1. This is legal; there is no timeout.
  - Reset asserted in any state, including FIRE, restores all reset values on the next edge: wb_boot drops, usb_pu returns to 1.
  - With SETTLE/DETACH/BOOT_HOLD = 1, each of those states lasts exactly one cycle.

Test Plan:
Bench parameters: SETTLE_CYCLES=4, DETACH_CYCLES=100, BOOT_HOLD_CYCLES=3. "Edge at T" means req_edge is sampled at clock edge T.

1. boot_req=1 held through reset release for 50 cycles -> busy=0, usb_pu=1, wb_boot=0 throughout. Then boot_req 0 for 1 cycle and back to 1 -> busy=1 on the following edge.
2. Nominal run, spi_cs=1, image_sel=2'b01, edge at T ->
   - WAIT_SPI at T+1, busy=1;
   - usb_pu=0 from T+5 through end;
   - {wb_s1,wb_s0}=01 from T+105;
   - wb_boot=1 for exactly cycles T+106..T+108;
   - HALT at T+109 with wb_boot=0 and usb_pu=0.
3. spi_cs=1 for 3 cycles, 0 for 1 cycle, then 1 -> DETACH is entered only after 4 further consecutive high cycles. usb_pu stays 1 until then.
4. image_sel=2'b10 at the edge, changed to 2'b11 one cycle later -> {wb_s1,wb_s0}=10 in ARM, FIRE and HALT.
5. Second boot_req rising edge during DETACH -> no effect. DETACH length stays 100 cycles and wb_boot is pulsed once only.
6. reset pulsed for 1 cycle during FIRE -> next edge: wb_boot=0, usb_pu=1, busy=0, wb_s=00. A new request edge then replays scenario 2 timing exactly.
